// File: rtl/flow_table_sched.sv
// Direct-mapped flow table sequencer: shares one read/write pipeline between
// foreground lookups, the post-reset table clear and a background aging sweep.
module flow_table_sched #(
  parameter int unsigned C_ID_WIDTH  = 12,
  parameter int unsigned C_KEY_WIDTH = 96,
  parameter int unsigned C_TS_WIDTH  = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid_tuple4search,
  input  logic [C_KEY_WIDTH-1:0]                in_tuple4search,
  output logic                                  out_valid_id,
  output logic [22:0]                           out_id,
  input  logic                                  cfg_age_en,
  input  logic [C_TS_WIDTH-1:0]                 cfg_age_thresh,
  output logic                                  out_evict_valid,
  output logic [C_ID_WIDTH-1:0]                 out_evict_id,
  output logic                                  out_init_done,
  output logic [15:0]                           out_drop_cnt,
  output logic                                  tbl_rd_en,
  output logic [C_ID_WIDTH-1:0]                 tbl_rd_addr,
  input  logic [C_KEY_WIDTH+C_TS_WIDTH:0]       tbl_rd_data,
  output logic                                  tbl_wr_en,
  output logic [C_ID_WIDTH-1:0]                 tbl_wr_addr,
  output logic [C_KEY_WIDTH+C_TS_WIDTH:0]       tbl_wr_data
);

  localparam int unsigned E   = 1 + C_KEY_WIDTH + C_TS_WIDTH;
  localparam int unsigned NCH = (C_KEY_WIDTH + C_ID_WIDTH - 1) / C_ID_WIDTH;

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  typedef enum logic {OWN_LOOKUP, OWN_AGE} own_t;

  function automatic logic [C_ID_WIDTH-1:0] idx_hash(input logic [C_KEY_WIDTH-1:0] key);
    logic [C_KEY_WIDTH-1:0] t;
    logic [C_ID_WIDTH-1:0]  h;
    t = key;
    h = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      h ^= t[C_ID_WIDTH-1:0];
      t = t >> C_ID_WIDTH;
    end
    return h;
  endfunction

  state_t                  state_q;
  logic [C_TS_WIDTH-1:0]   now_q;
  logic [C_ID_WIDTH-1:0]   init_ptr_q, sweep_ptr_q;

  logic                    s1_vld_q, s2_vld_q;
  own_t                    s1_own_q, s2_own_q;
  logic [C_KEY_WIDTH-1:0]  s1_key_q, s2_key_q;
  logic [C_ID_WIDTH-1:0]   s1_addr_q, s2_addr_q;
  logic [E-1:0]            s2_ent_q, s1_ent_d;

  logic                    lw_en_q;
  logic [C_ID_WIDTH-1:0]   lw_addr_q;
  logic [E-1:0]            lw_data_q;

  logic                    out_valid_id_q, out_evict_valid_q, out_init_done_q;
  logic [22:0]             out_id_q, id_d;
  logic [C_ID_WIDTH-1:0]   out_evict_id_q;
  logic [15:0]             out_drop_cnt_q;

  logic                    ent_vld, lk_new, lk_col, evict;
  logic [C_KEY_WIDTH-1:0]  ent_key;
  logic [C_TS_WIDTH-1:0]   ent_age;

  assign out_valid_id    = out_valid_id_q;
  assign out_id          = out_id_q;
  assign out_evict_valid = out_evict_valid_q;
  assign out_evict_id    = out_evict_id_q;
  assign out_init_done   = out_init_done_q;
  assign out_drop_cnt    = out_drop_cnt_q;

  // S0: lookups have strict priority over the aging sweep for the read slot
  always_comb begin
    tbl_rd_en   = 1'b0;
    tbl_rd_addr = '0;
    if (!reset && state_q == ST_RUN) begin
      if (in_valid_tuple4search) begin
        tbl_rd_en   = 1'b1;
        tbl_rd_addr = idx_hash(in_tuple4search);
      end else if (cfg_age_en) begin
        tbl_rd_en   = 1'b1;
        tbl_rd_addr = sweep_ptr_q;
      end
    end
  end

  // S2 decision; the write goes out combinationally so S1 forwarding only
  // needs the current write and the one registered from the previous cycle.
  assign ent_vld = s2_ent_q[E-1];
  assign ent_key = s2_ent_q[C_TS_WIDTH +: C_KEY_WIDTH];
  assign ent_age = now_q - s2_ent_q[C_TS_WIDTH-1:0];

  always_comb begin
    tbl_wr_en   = 1'b0;
    tbl_wr_addr = '0;
    tbl_wr_data = '0;
    lk_new      = 1'b0;
    lk_col      = 1'b0;
    evict       = 1'b0;
    if (!reset) begin
      if (state_q == ST_INIT) begin
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = init_ptr_q;
      end else if (s2_vld_q && s2_own_q == OWN_LOOKUP) begin
        if (ent_vld && ent_key != s2_key_q) begin
          lk_col = 1'b1;
        end else begin
          lk_new      = !ent_vld;
          tbl_wr_en   = 1'b1;
          tbl_wr_addr = s2_addr_q;
          tbl_wr_data = {1'b1, s2_key_q, now_q};
        end
      end else if (s2_vld_q && ent_vld && ent_age >= cfg_age_thresh) begin
        evict       = 1'b1;
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = s2_addr_q;
      end
    end
  end

  always_comb begin
    s1_ent_d = tbl_rd_data;
    if (lw_en_q && lw_addr_q == s1_addr_q)
      s1_ent_d = lw_data_q;
    if (tbl_wr_en && tbl_wr_addr == s1_addr_q)
      s1_ent_d = tbl_wr_data;
  end

  always_comb begin
    id_d                 = '0;
    id_d[C_ID_WIDTH-1:0] = s2_addr_q;
    id_d[22]             = lk_new;
    id_d[21]             = lk_col;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_INIT;
      now_q             <= '0;
      init_ptr_q        <= '0;
      sweep_ptr_q       <= '0;
      s1_vld_q          <= 1'b0;
      s1_own_q          <= OWN_LOOKUP;
      s1_key_q          <= '0;
      s1_addr_q         <= '0;
      s2_vld_q          <= 1'b0;
      s2_own_q          <= OWN_LOOKUP;
      s2_key_q          <= '0;
      s2_addr_q         <= '0;
      s2_ent_q          <= '0;
      lw_en_q           <= 1'b0;
      lw_addr_q         <= '0;
      lw_data_q         <= '0;
      out_valid_id_q    <= 1'b0;
      out_id_q          <= '0;
      out_evict_valid_q <= 1'b0;
      out_evict_id_q    <= '0;
      out_init_done_q   <= 1'b0;
      out_drop_cnt_q    <= '0;
    end else begin
      now_q     <= now_q + 1'b1;
      lw_en_q   <= tbl_wr_en;
      lw_addr_q <= tbl_wr_addr;
      lw_data_q <= tbl_wr_data;

      s1_vld_q  <= tbl_rd_en;
      s1_own_q  <= in_valid_tuple4search ? OWN_LOOKUP : OWN_AGE;
      s1_key_q  <= in_tuple4search;
      s1_addr_q <= tbl_rd_addr;

      s2_vld_q  <= s1_vld_q;
      s2_own_q  <= s1_own_q;
      s2_key_q  <= s1_key_q;
      s2_addr_q <= s1_addr_q;
      s2_ent_q  <= s1_ent_d;

      out_valid_id_q <= s2_vld_q && s2_own_q == OWN_LOOKUP;
      if (s2_vld_q && s2_own_q == OWN_LOOKUP)
        out_id_q <= id_d;
      out_evict_valid_q <= evict;
      if (evict)
        out_evict_id_q <= s2_addr_q;

      if (state_q == ST_INIT) begin
        init_ptr_q <= init_ptr_q + 1'b1;
        if (in_valid_tuple4search && out_drop_cnt_q != '1)
          out_drop_cnt_q <= out_drop_cnt_q + 1'b1;
        if (init_ptr_q == '1) begin
          state_q         <= ST_RUN;
          out_init_done_q <= 1'b1;
        end
      end else if (tbl_rd_en && !in_valid_tuple4search) begin
        sweep_ptr_q <= sweep_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flow_table_sched.sv
// Scoreboard bench for flow_table_sched with a behavioural read-old table RAM.
module tb_flow_table_sched;
  localparam int unsigned W = 12, K = 96, T = 32, E = 1 + K + T;
  localparam int DEPTH = 1 << W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, in_valid, out_valid_id, cfg_age_en, out_evict_valid, out_init_done;
  logic [K-1:0]  in_key;
  logic [22:0]   out_id;
  logic [T-1:0]  cfg_age_thresh;
  logic [W-1:0]  out_evict_id, tbl_rd_addr, tbl_wr_addr;
  logic [15:0]   out_drop_cnt;
  logic          tbl_rd_en, tbl_wr_en;
  logic [E-1:0]  tbl_rd_data, tbl_wr_data;

  flow_table_sched #(.C_ID_WIDTH(W), .C_KEY_WIDTH(K), .C_TS_WIDTH(T)) dut (
    .clk(clk), .reset(reset),
    .in_valid_tuple4search(in_valid), .in_tuple4search(in_key),
    .out_valid_id(out_valid_id), .out_id(out_id),
    .cfg_age_en(cfg_age_en), .cfg_age_thresh(cfg_age_thresh),
    .out_evict_valid(out_evict_valid), .out_evict_id(out_evict_id),
    .out_init_done(out_init_done), .out_drop_cnt(out_drop_cnt),
    .tbl_rd_en(tbl_rd_en), .tbl_rd_addr(tbl_rd_addr), .tbl_rd_data(tbl_rd_data),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data)
  );

  // Table RAM, pre-filled with junk so the clear is observable
  logic [E-1:0] mem [DEPTH];
  logic         ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < DEPTH; i++) begin
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        mem[i] <= r[E-1:0];
      end
      ram_ready <= 1'b1;
    end else if (tbl_wr_en) begin
      mem[tbl_wr_addr] <= tbl_wr_data;
    end
    if (tbl_rd_en) tbl_rd_data <= mem[tbl_rd_addr];
  end

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [22:0] id; int cyc; } exp_t;
  exp_t sbq[$];
  logic         mv [DEPTH];
  logic [K-1:0] mk [DEPTH];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] mhash(input logic [K-1:0] key);
    logic [8*W-1:0] p;
    logic [W-1:0]   h;
    p = '0;
    p[K-1:0] = key;
    h = '0;
    for (int c = 0; c < 8; c++) h ^= p[c*W +: W];
    return h;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
  endtask

  // Drives one lookup for one cycle and queues the in-order expected result
  task automatic send(input logic [K-1:0] key);
    logic [W-1:0] idx;
    logic [22:0]  r;
    idx = mhash(key);
    r = '0;
    r[W-1:0] = idx;
    if (!mv[idx]) begin
      r[22] = 1'b1;
      mv[idx] = 1'b1;
      mk[idx] = key;
    end else if (mk[idx] != key) begin
      r[21] = 1'b1;
    end
    sbq.push_back('{id: r, cyc: cyc});
    in_valid = 1'b1;
    in_key   = key;
    tick();
  endtask

  task automatic wait_init();
    for (int i = 0; i < 5000 && !out_init_done; i++) tick();
    check("init_done", 160'(out_init_done), 160'(1));
  endtask

  // Monitor: INIT writes, result scoreboard, evictions, AGE reads
  int init_exp = 0, last_init_cyc = 0, ev_cnt = 0, age_reads = 0;
  logic done_prev = 1'b0, arm_resume = 1'b0, resume_seen = 1'b0;
  logic [W-1:0] ev_last = '0, last_age = '0, resume_addr = '0;
  always @(negedge clk) begin
    if (reset) begin
      init_exp = 0;
    end else begin
      if (tbl_wr_en && !out_init_done) begin
        check("init_addr", 160'(tbl_wr_addr), 160'(init_exp));
        check("init_data", 160'(tbl_wr_data), 160'(0));
        if (init_exp == DEPTH - 1) last_init_cyc = cyc;
        init_exp++;
      end
      if (out_init_done && !done_prev)
        check("done_rise", 160'(cyc - last_init_cyc), 160'(1));
      if (out_valid_id) begin
        if (sbq.size() == 0) begin
          check("unexpected_result", 160'(out_valid_id), 160'(0));
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("out_id", 160'(out_id), 160'(e.id));
          check("latency", 160'(cyc - e.cyc), 160'(3));
        end
      end
      if (out_evict_valid) begin
        ev_cnt++;
        ev_last = out_evict_id;
      end
      if (tbl_rd_en && !in_valid) begin
        age_reads++;
        if (arm_resume && !resume_seen) begin
          resume_seen = 1'b1;
          resume_addr = tbl_rd_addr;
        end
        last_age = tbl_rd_addr;
      end
    end
    done_prev = out_init_done;
  end

  initial begin
    int ev_base, rd_base, rd_end, ev_end;
    logic [W-1:0] sw_exp;
    reset = 1'b1; in_valid = 1'b0; in_key = '0; cfg_age_en = 1'b0; cfg_age_thresh = '0;
    repeat (3) tick();
    check("rst_ctl", 160'({out_valid_id, out_id, out_evict_valid, out_evict_id, out_init_done,
                          out_drop_cnt, tbl_rd_en, tbl_rd_addr, tbl_wr_en, tbl_wr_addr}), 160'(0));
    check("rst_wdata", 160'(tbl_wr_data), 160'(0));
    reset = 1'b0;
    model_clear();

    // INIT: one lookup dropped
    idle(100);
    in_valid = 1'b1; in_key = K'(5); tick();
    in_valid = 1'b0;
    wait_init();
    check("init_cnt", 160'(init_exp), 160'(DEPTH));
    check("drop_cnt", 160'(out_drop_cnt), 160'(1));
    idle(2);

    // new, hit, collision via forwarding, back-to-back same key
    send(K'(5)); idle(5);
    send(K'(5)); idle(5);
    send(K'(5)); send(K'('h1004)); idle(6);
    check("col_nowrite_key", 160'(mem[5][T +: K]), 160'(5));
    check("col_nowrite_vld", 160'(mem[5][E-1]), 160'(1));
    send(K'('hA)); send(K'('hA)); send(K'('hA)); idle(6);
    repeat (8) send({$urandom, $urandom, $urandom});
    idle(6);
    check("drain_b", 160'(sbq.size()), 160'(0));

    // Reset with a lookup in flight: its result must never appear
    in_valid = 1'b1; in_key = K'('h33); tick();
    reset = 1'b1; in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    model_clear();
    wait_init();
    check("init_cnt2", 160'(init_exp), 160'(DEPTH));
    idle(2);

    // Aging: single entry evicted once the sweep sees it idle long enough
    cfg_age_en = 1'b1; cfg_age_thresh = T'(100);
    ev_base = ev_cnt;
    send(K'(5));
    idle(4400);
    check("evict_cnt", 160'(ev_cnt - ev_base), 160'(1));
    check("evict_id", 160'(ev_last), 160'(5));
    check("evict_mem", 160'(mem[5][E-1]), 160'(0));
    mv[5] = 1'b0;
    send(K'(5));

    // Continuous traffic starves aging; sweep resumes where it left off
    sw_exp  = last_age + 1'b1;
    rd_base = age_reads;
    ev_base = ev_cnt;
    repeat (5000) send(K'($urandom_range(0, 8191)));
    rd_end = age_reads;
    ev_end = ev_cnt;
    arm_resume = 1'b1;
    in_valid = 1'b0;
    check("age_reads_busy", 160'(rd_end - rd_base), 160'(0));
    check("evict_busy", 160'(ev_end - ev_base), 160'(0));
    for (int i = 0; i < 20 && !resume_seen; i++) tick();
    check("resume_seen", 160'(resume_seen), 160'(1));
    check("resume_addr", 160'(resume_addr), 160'(sw_exp));
    idle(5);
    check("drain_end", 160'(sbq.size()), 160'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
